fpu_shadow_dump_sched: RTL and testbench

Scheduler that shares the single UART transmitter between the fpu_add shadow-register dump channels. On a start request it walks the enabled channels in index order and asserts one dump_en bit at a time. It packs that channel's serial ch_out bitstream into bytes and sends them through the async_transmitter handshake, framed by header and trailer bytes. It sits between fpu_add (ch_out/ch_out_vld/ch_out_done/dump_en) and the async_transmitter (TxD_start/TxD_data/TxD_busy).

---
 rtl/fpu_dump_pkg.sv | 19 +
 rtl/fpu_dump_tx_if.sv | 38 +++
 rtl/fpu_shadow_dump_sched.sv | 226 ++++++++++++++++++++++
 tb/tb_fpu_shadow_dump_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_dump_pkg.sv
// Shared types and defaults for the fpu_add shadow-register dump scheduler.
package fpu_dump_pkg;

  localparam int unsigned NCH_DEF      = 8;
  localparam logic [7:0]  HDR_BASE_DEF = 8'hA0;
  localparam logic [7:0]  TRAILER_DEF  = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    HDR,
    DUMP,
    FLUSH,
    CNT_LO,
    CNT_HI,
    TRL
  } state_e;

endpackage

// File: rtl/fpu_dump_tx_if.sv
// Byte hand-off to async_transmitter: one-shot tx_en with a guard cycle and a held data byte.
module fpu_dump_tx_if
  import fpu_dump_pkg::*;
(
  input  logic       clk,
  input  logic       arst_l,
  input  logic       req,
  input  logic [7:0] req_data,
  input  logic       tx_busy,
  output logic       ack,
  output logic       tx_en,
  output logic [7:0] tx_data
);

  logic       tx_en_q, tx_en_d;
  logic [7:0] tx_data_q, tx_data_d;

  // tx_en_q doubles as the guard: busy may not have risen yet in the cycle after a strobe.
  always_comb begin
    ack       = req & ~tx_busy & ~tx_en_q;
    tx_en_d   = ack;
    tx_data_d = ack ? req_data : tx_data_q;
  end

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_en   = tx_en_q;
  assign tx_data = tx_data_q;

endmodule

// File: rtl/fpu_shadow_dump_sched.sv
// Walks masked fpu_add dump channels, packs each serial stream into framed UART bytes.
// Optional macro DUMP_BITCOUNT_EN appends a 16-bit per-channel bit count after each channel.
module fpu_shadow_dump_sched
  import fpu_dump_pkg::*;
#(
  parameter int unsigned NCH      = NCH_DEF,
  parameter logic [7:0]  HDR_BASE = HDR_BASE_DEF,
  parameter logic [7:0]  TRAILER  = TRAILER_DEF
) (
  input  logic           clk,
  input  logic           arst_l,
  input  logic           start,
  input  logic [NCH-1:0] ch_mask,
  input  logic [NCH-1:0] ch_out,
  input  logic [NCH-1:0] ch_out_vld,
  input  logic [NCH-1:0] ch_out_done,
  output logic [NCH-1:0] dump_en,
  output logic           tx_en,
  output logic [7:0]     tx_data,
  input  logic           tx_busy,
  output logic           busy,
  output logic           done
);

  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NCH-1:0]  mask_q, mask_d;
  logic [7:0]      buf_q, buf_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
`ifdef DUMP_BITCOUNT_EN
  logic [15:0]     bitcnt_q, bitcnt_d;
`endif

  logic            req, ack;
  logic [7:0]      req_data;
  logic            take, sel_done, scan_hit;
  logic [IW-1:0]   scan_idx;

  fpu_dump_tx_if u_tx_if (
    .clk      (clk),
    .arst_l   (arst_l),
    .req      (req),
    .req_data (req_data),
    .tx_busy  (tx_busy),
    .ack      (ack),
    .tx_en    (tx_en),
    .tx_data  (tx_data)
  );

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      mask_q   <= '0;
      buf_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef DUMP_BITCOUNT_EN
      bitcnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef DUMP_BITCOUNT_EN
      bitcnt_q <= bitcnt_d;
`endif
    end
  end

  // Outputs depend on registered state only; a full buffer (cnt_q==8) parks dump_en low.
  always_comb begin
    dump_en  = '0;
    req      = 1'b0;
    req_data = '0;
    case (state_q)
      HDR: begin
        req      = 1'b1;
        req_data = HDR_BASE | 8'(idx_q);
      end
      DUMP: begin
        if (cnt_q == 4'd8) begin
          req      = 1'b1;
          req_data = buf_q;
        end else begin
          dump_en[idx_q] = 1'b1;
        end
      end
      FLUSH: begin
        req      = (cnt_q != 4'd0);
        req_data = buf_q;
      end
`ifdef DUMP_BITCOUNT_EN
      CNT_LO: begin
        req      = 1'b1;
        req_data = bitcnt_q[7:0];
      end
      CNT_HI: begin
        req      = 1'b1;
        req_data = bitcnt_q[15:8];
      end
`endif
      TRL: begin
        req      = 1'b1;
        req_data = TRAILER;
      end
      default: begin
        req = 1'b0;
      end
    endcase
  end

  always_comb begin
    take     = dump_en[idx_q] & ch_out_vld[idx_q];
    sel_done = dump_en[idx_q] & ch_out_done[idx_q];
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int unsigned i = NCH; i > 0; i--) begin
      if (mask_q[i-1] && ((i - 1) >= 32'(idx_q))) begin
        scan_hit = 1'b1;
        scan_idx = IW'(i - 1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
`ifdef DUMP_BITCOUNT_EN
    bitcnt_d = bitcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d  = ch_mask;
          idx_d   = '0;
          buf_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (scan_hit) begin
          idx_d    = scan_idx;
`ifdef DUMP_BITCOUNT_EN
          bitcnt_d = '0;
`endif
          state_d  = HDR;
        end else begin
          state_d  = TRL;
        end
      end
      HDR: begin
        if (ack) state_d = DUMP;
      end
      DUMP: begin
        if (cnt_q == 4'd8) begin
          if (ack) begin
            buf_d = '0;
            cnt_d = '0;
          end
        end else begin
          if (take) begin
            buf_d[cnt_q[2:0]] = ch_out[idx_q];
            cnt_d             = cnt_q + 4'd1;
`ifdef DUMP_BITCOUNT_EN
            if (bitcnt_q != 16'hFFFF) bitcnt_d = bitcnt_q + 16'd1;
`endif
          end
          if (sel_done) state_d = FLUSH;
        end
      end
      FLUSH: begin
        // An empty buffer needs no byte; a full one (done with the 8th bit) is sent whole.
        if ((cnt_q == 4'd0) || ack) begin
          buf_d         = '0;
          cnt_d         = '0;
          mask_d[idx_q] = 1'b0;
`ifdef DUMP_BITCOUNT_EN
          state_d       = CNT_LO;
`else
          state_d       = SCAN;
`endif
        end
      end
`ifdef DUMP_BITCOUNT_EN
      CNT_LO: begin
        if (ack) state_d = CNT_HI;
      end
      CNT_HI: begin
        if (ack) state_d = SCAN;
      end
`endif
      TRL: begin
        if (ack) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_fpu_shadow_dump_sched.sv
// Directed bench for fpu_shadow_dump_sched with channel stream and UART busy models.
module tb_fpu_shadow_dump_sched;

  localparam int NCH = 8;

  logic           clk = 1'b0;
  logic           arst_l = 1'b0;
  logic           start = 1'b0;
  logic [NCH-1:0] ch_mask = '0;
  logic [NCH-1:0] ch_out = '0;
  logic [NCH-1:0] ch_out_vld = '0;
  logic [NCH-1:0] ch_out_done = '0;
  logic [NCH-1:0] dump_en;
  logic           tx_en;
  logic [7:0]     tx_data;
  logic           tx_busy = 1'b0;
  logic           busy;
  logic           done;

  fpu_shadow_dump_sched #(.NCH(NCH), .HDR_BASE(8'hA0), .TRAILER(8'h0A)) dut (
    .clk         (clk),
    .arst_l      (arst_l),
    .start       (start),
    .ch_mask     (ch_mask),
    .ch_out      (ch_out),
    .ch_out_vld  (ch_out_vld),
    .ch_out_done (ch_out_done),
    .dump_en     (dump_en),
    .tx_en       (tx_en),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Channel stream model: bit i of ch_bits[c] is the i-th bit channel c offers.
  logic [31:0] ch_bits [NCH];
  int          ch_len  [NCH];
  int          load_gen = 0;
  int          seen_gen = 0;
  int          pos     [NCH];
  bit          pend    [NCH];

  always @(negedge clk) begin
    if (seen_gen != load_gen) begin
      seen_gen = load_gen;
      for (int c = 0; c < NCH; c++) begin
        pos[c]  = 0;
        pend[c] = 1'b0;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (pend[c]) pos[c]++;
      ch_out_vld[c]  = (pos[c] < ch_len[c]);
      ch_out[c]      = ch_out_vld[c] ? ch_bits[c][pos[c]] : 1'b0;
      ch_out_done[c] = (pos[c] >= ch_len[c]);
      pend[c]        = dump_en[c] & ch_out_vld[c];
    end
  end

  // Transmitter model plus byte capture and protocol watchers.
  int          busy_cyc = 3;
  int          busy_cnt = 0;
  logic [7:0]  cap [256];
  int          cap_n = 0;
  int          viol = 0;
  logic        tx_en_prev = 1'b0;
  logic [7:0]  cur_mask = '0;

  always @(negedge clk) begin
    if (tx_en) begin
      if (tx_busy) viol++;
      if (tx_en_prev) viol++;
      cap[cap_n % 256] = tx_data;
      cap_n++;
      busy_cnt = busy_cyc;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy    = (busy_cnt != 0);
    tx_en_prev = tx_en;
    if ((dump_en & (dump_en - 8'd1)) != 8'd0) viol++;
    if ((dump_en & ~cur_mask) != 8'd0) viol++;
  end

  task automatic load_channels(input int c0, input int l0, input logic [31:0] b0,
                               input int c1, input int l1, input logic [31:0] b1,
                               input int c2, input int l2, input logic [31:0] b2);
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      ch_len[c]  = 0;
      ch_bits[c] = '0;
    end
    if (c0 >= 0) begin ch_len[c0] = l0; ch_bits[c0] = b0; end
    if (c1 >= 0) begin ch_len[c1] = l1; ch_bits[c1] = b1; end
    if (c2 >= 0) begin ch_len[c2] = l2; ch_bits[c2] = b2; end
    load_gen++;
  endtask

  task automatic run_seq(input string name, input logic [7:0] mask,
                         input logic [7:0] exp [$], input int restart_at);
    int base;
    int vbase;
    int cyc;
    int n;
    base     = cap_n;
    vbase    = viol;
    cur_mask = mask;
    @(negedge clk);
    ch_mask = mask;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restart_at);
    end
    start = 1'b0;
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", name, done, cyc);
    end
    cyc = 0;
    while (busy_cnt != 0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
    n = cap_n - base;
    vectors++;
    if (n != exp.size()) begin
      miscompares++;
      $display("FAIL %s_byte_count: got %0d bytes, required %0d", name, n, exp.size());
    end
    for (int i = 0; i < exp.size() && i < n; i++) begin
      vectors++;
      if (cap[(base + i) % 256] !== exp[i]) begin
        miscompares++;
        $display("FAIL %s_byte%0d: got %h, required %h", name, i, cap[(base + i) % 256], exp[i]);
      end
    end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_end_flags: busy=%b done=%b, required busy=0 done=1", name, busy, done);
    end
    vectors++;
    if (viol != vbase) begin
      miscompares++;
      $display("FAIL %s_protocol: %0d handshake/dump_en violations, required 0", name, viol - vbase);
    end
  endtask

  task automatic test_reset();
    arst_l = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (dump_en !== 8'h00) begin miscompares++; $display("FAIL reset_dump_en: got %h, required 00", dump_en); end
    vectors++;
    if (tx_en !== 1'b0) begin miscompares++; $display("FAIL reset_tx_en: got %b, required 0", tx_en); end
    vectors++;
    if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: busy=%b done=%b, required 0 0", busy, done);
    end
    @(negedge clk);
    arst_l = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_empty_mask();
    logic [7:0] e [$];
    load_channels(-1, 0, '0, -1, 0, '0, -1, 0, '0);
    e = '{8'h0A};
    run_seq("empty", 8'h00, e, 0);
  endtask

  task automatic test_single_ch2();
    logic [7:0] e [$];
    load_channels(2, 8, 32'h0000_008D, -1, 0, '0, -1, 0, '0);
`ifdef DUMP_BITCOUNT_EN
    e = '{8'hA2, 8'h8D, 8'h08, 8'h00, 8'h0A};
`else
    e = '{8'hA2, 8'h8D, 8'h0A};
`endif
    run_seq("ch2", 8'h04, e, 0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] e [$];
    load_channels(0, 11, 32'h0000_07FF, -1, 0, '0, -1, 0, '0);
`ifdef DUMP_BITCOUNT_EN
    e = '{8'hA0, 8'hFF, 8'h07, 8'h0B, 8'h00, 8'h0A};
`else
    e = '{8'hA0, 8'hFF, 8'h07, 8'h0A};
`endif
    run_seq("ch0_restart", 8'h01, e, 30);
  endtask

  task automatic test_stall();
    logic [7:0] e [$];
    busy_cyc = 200;
    load_channels(0, 5, 32'h0000_0015, 7, 16, 32'h0000_C33C, 3, 4, 32'h0000_000F);
`ifdef DUMP_BITCOUNT_EN
    e = '{8'hA0, 8'h15, 8'h05, 8'h00, 8'hA7, 8'h3C, 8'hC3, 8'h10, 8'h00, 8'h0A};
`else
    e = '{8'hA0, 8'h15, 8'hA7, 8'h3C, 8'hC3, 8'h0A};
`endif
    run_seq("stall", 8'h81, e, 0);
    busy_cyc = 3;
  endtask

  task automatic test_reset_mid_dump();
    logic [7:0] e [$];
    int cyc;
    int cap_hold;
    load_channels(3, 32, 32'hDEAD_BEEF, -1, 0, '0, -1, 0, '0);
    cur_mask = 8'h08;
    @(negedge clk);
    ch_mask = 8'h08;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (!dump_en[3] && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (dump_en[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_reach_dump: dump_en=%h after %0d cycles, required bit3 set", dump_en, cyc);
    end
    repeat (6) @(negedge clk);
    #2;
    arst_l = 1'b0;
    #1;
    vectors++;
    if (dump_en !== 8'h00 || tx_en !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: dump_en=%h tx_en=%b tx_data=%h busy=%b done=%b, required all 0",
               dump_en, tx_en, tx_data, busy, done);
    end
    cap_hold = cap_n;
    repeat (3) @(negedge clk);
    vectors++;
    if (cap_n != cap_hold) begin
      miscompares++;
      $display("FAIL rst_mid_quiet: %0d bytes during reset, required 0", cap_n - cap_hold);
    end
    arst_l = 1'b1;
    repeat (2) @(negedge clk);
    load_channels(3, 4, 32'h0000_0003, -1, 0, '0, -1, 0, '0);
`ifdef DUMP_BITCOUNT_EN
    e = '{8'hA3, 8'h03, 8'h04, 8'h00, 8'h0A};
`else
    e = '{8'hA3, 8'h03, 8'h0A};
`endif
    run_seq("rst_restart", 8'h08, e, 0);
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin
      ch_len[c]  = 0;
      ch_bits[c] = '0;
    end
    test_reset();
    test_empty_mask();
    test_single_ch2();
    test_back_to_back();
    test_stall();
    test_reset_mid_dump();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
